// File: rtl/kitchen_timer_n.sv
// Countdown kitchen timer: N BCD digits with optional mm:ss moduli, tick prescaler,
// run/pause/alarm control, preset recall and a timed blinking alarm.
module kitchen_timer_n #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned MMSS        = 1,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic [DIGITS-1:0]     inc,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  alarm,
  output logic                  blink,
  output logic                  zero
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned AW = $clog2(ALARM_TICKS + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_ALARM = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_preset;
  logic [PW-1:0] r_presc;
  logic [AW-1:0] r_acnt;
  logic          r_blink;
  logic          r_running;
  logic          r_alarm;
  logic          r_zero;

  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_preset_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic [AW-1:0] w_acnt_nxt;
  logic          w_blink_nxt;
  logic          w_tick;
  logic          w_count_nz;
  logic          w_count_one;
  logic [CW-1:0] w_dec;
  logic [CW-1:0] w_incd;

  // Highest value a digit may hold: tens-of-seconds/minutes digits stop at 5 in mm:ss mode.
  function automatic logic [3:0] f_max(input int idx);
    if ((MMSS == 1) && ((idx % 2) == 1)) return 4'd5;
    else                                 return 4'd9;
  endfunction

  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
  assign w_count_nz  = |r_count;
  assign w_count_one = (r_count == CW'(1));

  // Decrement with borrow rippling up from digit 0.
  always_comb begin : dec_chain
    logic v_borrow;
    v_borrow = 1'b1;
    w_dec    = r_count;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v_borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = f_max(i);
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          v_borrow        = 1'b0;
        end
      end
    end
  end

  // Independent per-digit increment, wrapping without carry.
  always_comb begin : inc_digits
    w_incd = r_count;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (inc[i]) begin
        if (r_count[4*i +: 4] >= f_max(i)) w_incd[4*i +: 4] = 4'd0;
        else                               w_incd[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
      end
    end
  end

  // Next-state logic; priority clear > start_stop > tick > inc.
  always_comb begin : next_state
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_preset_nxt = r_preset;
    w_acnt_nxt   = r_acnt;
    w_blink_nxt  = r_blink;
    w_presc_nxt  = w_tick ? '0 : r_presc + PW'(1);

    if (clear) begin
      w_state_nxt  = ST_IDLE;
      w_count_nxt  = '0;
      w_preset_nxt = '0;
      w_acnt_nxt   = '0;
      w_blink_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_stop) begin
            if (w_count_nz) begin
              w_state_nxt  = ST_RUN;
              w_preset_nxt = r_count;
              w_presc_nxt  = '0;
            end
          end else begin
            w_count_nxt = w_incd;
          end
        end
        ST_RUN: begin
          if (start_stop) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_tick) begin
            if (w_count_one) begin
              w_state_nxt = ST_ALARM;
              w_count_nxt = '0;
              w_acnt_nxt  = '0;
              w_blink_nxt = 1'b1;
            end else begin
              w_count_nxt = w_dec;
            end
          end
        end
        ST_PAUSE: begin
          if (start_stop) begin
            if (w_count_nz) begin
              w_state_nxt = ST_RUN;
              w_presc_nxt = '0;
            end
          end else begin
            w_count_nxt = w_incd;
          end
        end
        ST_ALARM: begin
          if (start_stop) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = r_preset;
            w_acnt_nxt  = '0;
            w_blink_nxt = 1'b0;
          end else if (w_tick) begin
            if (r_acnt == AW'(ALARM_TICKS - 1)) begin
              w_state_nxt = ST_IDLE;
              w_count_nxt = r_preset;
              w_acnt_nxt  = '0;
              w_blink_nxt = 1'b0;
            end else begin
              w_acnt_nxt  = r_acnt + AW'(1);
              w_blink_nxt = ~r_blink;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Status flags are registered from the next-state values so they align with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_preset  <= '0;
      r_presc   <= '0;
      r_acnt    <= '0;
      r_blink   <= 1'b0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
      r_zero    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_preset  <= w_preset_nxt;
      r_presc   <= w_presc_nxt;
      r_acnt    <= w_acnt_nxt;
      r_blink   <= w_blink_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_alarm   <= (w_state_nxt == ST_ALARM);
      r_zero    <= ~|w_count_nxt;
    end
  end

  assign count   = r_count;
  assign running = r_running;
  assign alarm   = r_alarm;
  assign blink   = r_blink;
  assign zero    = r_zero;

endmodule

// File: tb/tb_kitchen_timer_n.sv
// Directed bench for kitchen_timer_n: mm:ss instance plus an all-decimal instance.
module tb_kitchen_timer_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_stop;
  logic        clear;
  logic [3:0]  inc;
  logic [15:0] count;
  logic        running, alarm, blink, zero;
  logic [15:0] count_b;
  logic        running_b, alarm_b, blink_b, zero_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kitchen_timer_n #(.DIGITS(4), .TICK_DIV(4), .MMSS(1), .ALARM_TICKS(3)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .inc(inc),
    .count(count), .running(running), .alarm(alarm), .blink(blink), .zero(zero)
  );

  kitchen_timer_n #(.DIGITS(4), .TICK_DIV(4), .MMSS(0), .ALARM_TICKS(3)) dut_b (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .inc(inc),
    .count(count_b), .running(running_b), .alarm(alarm_b), .blink(blink_b), .zero(zero_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
  endtask

  task automatic pulse_inc(input logic [3:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      inc = m; cyc(1); inc = 4'd0;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b0; clear = 1'b0; inc = 4'd0;
    cyc(2);
    reset = 1'b0;
    check("rst_count", 32'(count), 32'h0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);

    pulse_ss();
    check("ss_zero_running", 32'(running), 32'd0);
    check("ss_zero_count", 32'(count), 32'h0);

    pulse_inc(4'b0001, 3);
    pulse_inc(4'b0010, 1);
    check("set_count", 32'(count), 32'h0013);
    check("set_zero", 32'(zero), 32'd0);
    check("set_running", 32'(running), 32'd0);

    // Countdown 00:13 to alarm; ticks every 4 cycles after the start pulse
    pulse_ss();
    check("run_running", 32'(running), 32'd1);
    cyc(3);
    check("run_hold", 32'(count), 32'h0013);
    cyc(1);
    check("run_first_dec", 32'(count), 32'h0012);
    cyc(8);
    check("run_0010", 32'(count), 32'h0010);
    cyc(4);
    check("run_borrow", 32'(count), 32'h0009);
    cyc(32);
    check("run_0001", 32'(count), 32'h0001);
    check("run_0001_run", 32'(running), 32'd1);
    cyc(4);
    check("alm_count", 32'(count), 32'h0);
    check("alm_alarm", 32'(alarm), 32'd1);
    check("alm_running", 32'(running), 32'd0);
    check("alm_blink0", 32'(blink), 32'd1);
    check("alm_zero", 32'(zero), 32'd1);
    cyc(4);
    check("alm_blink1", 32'(blink), 32'd0);
    check("alm_still", 32'(alarm), 32'd1);
    cyc(4);
    check("alm_blink2", 32'(blink), 32'd1);
    cyc(4);
    check("alm_to_alarm", 32'(alarm), 32'd0);
    check("alm_to_blink", 32'(blink), 32'd0);
    check("alm_to_count", 32'(count), 32'h0013);

    // Digit-1 borrow wraps to 5 in mm:ss, 9 in decimal
    do_clear();
    pulse_inc(4'b0100, 1);
    check("wrap_set", 32'(count), 32'h0100);
    pulse_ss();
    cyc(4);
    check("wrap_mmss", 32'(count), 32'h0059);
    check("wrap_dec", 32'(count_b), 32'h0099);

    // Pause, edit, resume
    do_clear();
    pulse_inc(4'b0001, 5);
    pulse_ss();
    cyc(8);
    check("pause_pre", 32'(count), 32'h0003);
    pulse_ss();
    check("pause_running", 32'(running), 32'd0);
    check("pause_count", 32'(count), 32'h0003);
    pulse_inc(4'b0001, 1);
    check("pause_inc", 32'(count), 32'h0004);
    pulse_ss();
    check("resume_running", 32'(running), 32'd1);
    cyc(3);
    check("resume_hold", 32'(count), 32'h0004);
    cyc(1);
    check("resume_dec", 32'(count), 32'h0003);

    do_clear();
    check("clr_count", 32'(count), 32'h0);
    check("clr_running", 32'(running), 32'd0);
    check("clr_zero", 32'(zero), 32'd1);

    // Preset 0002, acknowledge after one alarm tick
    pulse_inc(4'b0001, 2);
    pulse_ss();
    cyc(8);
    check("ack_alarm", 32'(alarm), 32'd1);
    check("ack_blink0", 32'(blink), 32'd1);
    cyc(4);
    check("ack_blink1", 32'(blink), 32'd0);
    pulse_ss();
    check("ack_alarm_off", 32'(alarm), 32'd0);
    check("ack_count", 32'(count), 32'h0002);
    check("ack_blink_off", 32'(blink), 32'd0);
    check("ack_running", 32'(running), 32'd0);

    // inc together with start_stop: start wins
    inc = 4'b0001; start_stop = 1'b1; cyc(1); inc = 4'd0; start_stop = 1'b0;
    check("incss_running", 32'(running), 32'd1);
    check("incss_count", 32'(count), 32'h0002);

    // Digit 0 wraps 9 -> 0 without carry; digit 1 wraps 5 -> 0
    do_clear();
    pulse_inc(4'b0001, 9);
    check("inc_nine", 32'(count), 32'h0009);
    pulse_inc(4'b0001, 1);
    check("inc_nocarry", 32'(count), 32'h0000);
    pulse_inc(4'b0011, 6);
    check("inc_mmss_wrap", 32'(count), 32'h0006);
    check("inc_dec_b", 32'(count_b), 32'h0066);

    // Reset while in ALARM
    do_clear();
    pulse_inc(4'b0001, 1);
    pulse_ss();
    cyc(4);
    check("rsta_alarm_pre", 32'(alarm), 32'd1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("rsta_count", 32'(count), 32'h0);
    check("rsta_alarm", 32'(alarm), 32'd0);
    check("rsta_blink", 32'(blink), 32'd0);
    check("rsta_zero", 32'(zero), 32'd1);
    check("rsta_running", 32'(running), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
